dcache_store_buffer: RTL and testbench
======================================

// Module: dcache_store_buffer
// PURPOSE
//  Parametrised posted-write buffer between dcache write port and the shared memory interconnect.
//  Accepts up to DEPTH stores of 1/2/4/8 bytes at any byte alignment (physical address).
//  Drains them in order as bus beats that never cross a BUS_BYTES boundary.
//  Exposes a read-hazard check so the dcache read path can stall on pending overlapping stores.
// PARAMETERS
//  DEPTH      4   store entries held (power of 2, >=2)
//  ADDR_W     32  physical address width
//  DATA_W     64  store data width (max store = DATA_W/8 bytes)
//  BUS_BYTES  4   bytes per bus beat (power of 2); mem_data is 8*BUS_BYTES wide
// PORTS
//  clk             in   1          clock
//  reset           in   1          reset (one clock; reset is asynchronous and active-low)
//  wr_req_valid    in   1          store request valid
//  wr_req_ready    out  1          buffer can accept a store
//  wr_req_address  in   ADDR_W     physical byte address of first byte
//  wr_req_data     in   DATA_W     store data, little-endian, low-justified
//  wr_size_in      in   2          00=1B 01=2B 10=4B 11=8B
//  chk_address     in   ADDR_W     read address to test for hazard
//  chk_hit         out  1          pending store touches chk_address's 8-byte block
//  count           out  log2(DEPTH)+1  entries held
//  empty           out  1          count==0
//  mem_addr        out  ADDR_W     byte address of current beat
//  mem_data        out  8*BUS_BYTES beat data, low-justified, unused bytes zero
//  mem_wr_size     out  log2(BUS_BYTES)  beat bytes minus 1
//  mem_rd_wr       out  1          1 = write, driven only while mem_en
//  mem_en          out  1          this block owns/drives the bus (== bus_busy_out)
//  mem_req         out  1          bus request
//  mem_data_valid  in   1          beat acknowledged by memory
//  grant_in        in   1          daisy-chain grant in
//  grant_out       out  1          grant passed downstream
//  bus_busy_in     in   1          bus owned by another agent
//  bus_busy_out    out  1          bus owned by this block
// BEHAVIOUR
//  Reset (async, reset==0): FIFO pointers/count=0, FSM=IDLE, beat counter=0; outputs mem_req=0,
//   bus_busy_out=mem_en=0, mem_rd_wr=0, mem_addr/mem_data/mem_wr_size=0, chk_hit=0, empty=1,
//   wr_req_ready=1. Reset mid-drain aborts the beat immediately; buffered stores are discarded.
//  Enqueue: accept on rising clk when wr_req_valid & wr_req_ready; wr_req_ready = (count<DEPTH),
//   from registered count only (full + same-cycle pop still not ready). Push+pop same cycle: count unchanged.
//  Beat split: o = addr mod BUS_BYTES, S = size bytes; beats = ceil((o+S)/BUS_BYTES) (max 3 at defaults).
//   Beat k address = addr + bytes already sent; beat length = min(remaining, BUS_BYTES - (beat addr mod BUS_BYTES)).
//  FSM: IDLE --(!empty)--> REQ --(grant_in & !bus_busy_in)--> BEAT.
//   REQ: mem_req=1, grant_out=0. Other states: mem_req=0, grant_out=grant_in.
//   BEAT: bus_busy_out=mem_en=1, mem_rd_wr=1, head entry beat k on mem_addr/mem_data/mem_wr_size, held stable
//    until mem_data_valid. On mem_data_valid: non-last beat -> k+1, stay BEAT; last beat -> pop head, k=0, IDLE.
//   Bus released for >=1 cycle between stores (fairness); ack in first BEAT cycle is legal.
//   mem_data_valid outside BEAT is ignored.
//  chk_hit (combinational): any valid entry, including head mid-drain, whose first or last byte lies in
//   chk_address[ADDR_W-1:3]'s block. Entry stays visible until its final-beat ack pops it.
//  Address arithmetic wraps modulo 2^ADDR_W; no fault checking here (TLB done upstream).
// TESTING
//  1. Reset, push 4B @0x100 data 0xDDCCBBAA, grant at once -> one beat: addr 0x100, size 2'b11, data 0xDDCCBBAA; empty after ack.
//  2. 8B @0x103 data 0x8877665544332211 -> beats (0x103,1B,0x11),(0x104,4B,0x55443322),(0x108,3B,0x887766).
//  3. Push 5 stores with no grant -> ready drops after 4th, count=4; one pop -> ready=1 next cycle, FIFO order kept.
//  4. Pending 2B @0x1FF: chk 0x1F8 -> hit=1, chk 0x200 -> hit=1, chk 0x208 -> hit=0; after final ack hit=0.
//  5. bus_busy_in=1 with grant_in=1 -> stays REQ, mem_en=0; idle, grant_out mirrors grant_in.
//  6. reset low mid-beat 2 of 3 -> bus_busy_out/mem_req drop without clk edge; count=0, buffer empty.

Source files
------------

// File: rtl/dcache_store_buffer.sv
// Posted-write buffer: queues 1/2/4/8-byte stores and drains each as bus-aligned beats in order.
// Zero-latency hazard check (chk_hit); enqueue stalls only when all DEPTH entries are held.
module dcache_store_buffer #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int BUS_BYTES = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_req_valid,
   output logic                         wr_req_ready,
   input  logic [ADDR_W-1:0]            wr_req_address,
   input  logic [DATA_W-1:0]            wr_req_data,
   input  logic [1:0]                   wr_size_in,
   input  logic [ADDR_W-1:0]            chk_address,
   output logic                         chk_hit,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         empty,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [8*BUS_BYTES-1:0]       mem_data,
   output logic [$clog2(BUS_BYTES)-1:0] mem_wr_size,
   output logic                         mem_rd_wr,
   output logic                         mem_en,
   output logic                         mem_req,
   input  logic                         mem_data_valid,
   input  logic                         grant_in,
   output logic                         grant_out,
   input  logic                         bus_busy_in,
   output logic                         bus_busy_out
);
   localparam int PW   = $clog2(DEPTH);
   localparam int OW   = $clog2(BUS_BYTES);
   localparam int MAXB = DATA_W / 8;
   localparam int CW   = $clog2((MAXB > BUS_BYTES) ? MAXB : BUS_BYTES) + 1;

   typedef enum logic [1:0] {IDLE, REQ, BEAT} state_t;

   logic [ADDR_W-1:0]      addr_q [DEPTH];
   logic [DATA_W-1:0]      data_q [DEPTH];
   logic [1:0]             size_q [DEPTH];
   logic [PW-1:0]          rd_ptr, wr_ptr;
   logic [CW-1:0]          sent;
   state_t                 state;

   logic                   push, pop, last_beat;
   logic [CW-1:0]          store_bytes, remain, room, beat_len;
   logic [ADDR_W-1:0]      beat_addr;
   logic [8*BUS_BYTES-1:0] beat_raw;

   function automatic logic entry_hits(input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                                       input logic [ADDR_W-1:0] c);
      logic [ADDR_W-1:0] last;
      last = a + ((ADDR_W'(1) << sz) - ADDR_W'(1));
      return (((a ^ c) & ~ADDR_W'(7)) == '0) || (((last ^ c) & ~ADDR_W'(7)) == '0);
   endfunction

   assign wr_req_ready = (count < (PW+1)'(DEPTH));
   assign empty        = (count == '0);
   assign push         = wr_req_valid & wr_req_ready;

   // Current beat of the head entry: `sent` bytes already acknowledged
   assign store_bytes = CW'(1) << size_q[rd_ptr];
   assign beat_addr   = addr_q[rd_ptr] + ADDR_W'(sent);
   assign remain      = store_bytes - sent;
   assign room        = CW'(BUS_BYTES) - CW'(beat_addr[OW-1:0]);
   assign beat_len    = (remain < room) ? remain : room;
   assign last_beat   = ((sent + beat_len) == store_bytes);
   assign pop         = mem_en & mem_data_valid & last_beat;
   assign beat_raw    = (8*BUS_BYTES)'(data_q[rd_ptr] >> {sent, 3'b000});

   assign mem_addr     = mem_en ? beat_addr : '0;
   assign mem_wr_size  = mem_en ? OW'(beat_len - CW'(1)) : '0;
   assign mem_rd_wr    = mem_en;
   assign bus_busy_out = mem_en;
   assign grant_out    = (state == REQ) ? 1'b0 : grant_in;

   always_comb begin
      mem_data = '0;
      if (mem_en) begin
         for (int b = 0; b < BUS_BYTES; b++) begin
            if (CW'(b) < beat_len) mem_data[8*b +: 8] = beat_raw[8*b +: 8];
         end
      end
   end

   // Head stays visible until its final beat is acknowledged
   always_comb begin
      chk_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PW'(PW'(i) - rd_ptr)} < count) &&
             entry_hits(addr_q[i], size_q[i], chk_address))
            chk_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= wr_req_address;
         data_q[wr_ptr] <= wr_req_data;
         size_q[wr_ptr] <= wr_size_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         sent    <= '0;
         mem_req <= 1'b0;
         mem_en  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         case (state)
            IDLE: if (!empty) begin
               state   <= REQ;
               mem_req <= 1'b1;
            end
            REQ: if (grant_in && !bus_busy_in) begin
               state   <= BEAT;
               mem_req <= 1'b0;
               mem_en  <= 1'b1;
            end
            BEAT: if (mem_data_valid) begin
               // Returning through IDLE frees the bus for a cycle between stores
               if (last_beat) begin
                  state  <= IDLE;
                  mem_en <= 1'b0;
                  sent   <= '0;
               end else begin
                  sent <= sent + beat_len;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_en  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed and randomized checks of dcache_store_buffer against a byte-level store queue model.
module tb_dcache_store_buffer;
   localparam int DEPTH = 4, ADDR_W = 32, DATA_W = 64, BB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b0;
   logic              wr_req_valid = 1'b0, wr_req_ready;
   logic [ADDR_W-1:0] wr_req_address = '0;
   logic [DATA_W-1:0] wr_req_data = '0;
   logic [1:0]        wr_size_in = '0;
   logic [ADDR_W-1:0] chk_address = '0;
   logic              chk_hit;
   logic [2:0]        count;
   logic              empty;
   logic [ADDR_W-1:0] mem_addr;
   logic [8*BB-1:0]   mem_data;
   logic [1:0]        mem_wr_size;
   logic              mem_rd_wr, mem_en, mem_req;
   logic              mem_data_valid = 1'b0, grant_in = 1'b0, grant_out;
   logic              bus_busy_in = 1'b0, bus_busy_out;

   dcache_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUS_BYTES(BB)) dut (
      .clk(clk), .reset(reset),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
      .wr_req_address(wr_req_address), .wr_req_data(wr_req_data), .wr_size_in(wr_size_in),
      .chk_address(chk_address), .chk_hit(chk_hit), .count(count), .empty(empty),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_size(mem_wr_size),
      .mem_rd_wr(mem_rd_wr), .mem_en(mem_en), .mem_req(mem_req),
      .mem_data_valid(mem_data_valid), .grant_in(grant_in), .grant_out(grant_out),
      .bus_busy_in(bus_busy_in), .bus_busy_out(bus_busy_out)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [63:0] d;
      logic [1:0]  sz;
   } st_t;

   st_t         q[$];
   logic [31:0] eb_a[$];
   int          eb_n[$];
   logic [31:0] eb_d[$];
   int          n_chk = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beats are formed byte by byte: a new beat starts at the first byte or on a bus boundary
   function automatic void split(input st_t s);
      int n, k;
      logic [31:0] ad;
      eb_a.delete(); eb_n.delete(); eb_d.delete();
      n = 1 << s.sz;
      for (int i = 0; i < n; i++) begin
         ad = s.a + 32'(i);
         if (i == 0 || (ad % BB) == 0) begin
            eb_a.push_back(ad); eb_n.push_back(0); eb_d.push_back(32'd0);
         end
         k = eb_d.size() - 1;
         eb_d[k] = eb_d[k] | (32'(s.d[8*i +: 8]) << (8 * eb_n[k]));
         eb_n[k] = eb_n[k] + 1;
      end
   endfunction

   function automatic logic model_hit(input logic [31:0] c);
      logic [31:0] last;
      foreach (q[i]) begin
         last = q[i].a + (32'd1 << q[i].sz) - 32'd1;
         if ((q[i].a >> 3) == (c >> 3) || (last >> 3) == (c >> 3)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic push_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
      logic acc;
      st_t  s;
      acc = (q.size() < DEPTH);
      wr_req_valid = 1'b1; wr_req_address = a; wr_req_data = d; wr_size_in = sz;
      #1 check("wr_ready", wr_req_ready, acc);
      tick();
      wr_req_valid = 1'b0;
      s.a = a; s.d = d; s.sz = sz;
      if (acc) q.push_back(s);
   endtask

   task automatic drain_head(input int max_hold);
      st_t s;
      int  t;
      s = q[0];
      split(s);
      grant_in = 1'b1;
      bus_busy_in = 1'b1;
      repeat ($urandom_range(0, 3)) tick();
      check("busy_blocks", mem_en, 1'b0);
      bus_busy_in = 1'b0;
      t = 0;
      while (!mem_en && t < 40) begin tick(); t++; end
      check("bus_won", mem_en, 1'b1);
      grant_in = 1'b0;
      if (!mem_en) begin void'(q.pop_front()); return; end
      for (int j = 0; j < eb_a.size(); j++) begin
         repeat ($urandom_range(0, max_hold)) tick();
         chk_address = s.a;
         #1;
         check("beat_addr", mem_addr, eb_a[j]);
         check("beat_size", mem_wr_size, eb_n[j] - 1);
         check("beat_data", mem_data, eb_d[j]);
         check("beat_wr", {mem_rd_wr, bus_busy_out}, 2'b11);
         check("hit_mid_drain", chk_hit, model_hit(chk_address));
         mem_data_valid = 1'b1;
         tick();
         mem_data_valid = 1'b0;
      end
      void'(q.pop_front());
      check("released", mem_en, 1'b0);
      check("count_after_pop", count, q.size());
   endtask

   initial begin
      st_t s;
      int  n;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_en", {mem_en, bus_busy_out, mem_rd_wr}, 3'b000);
      check("rst_mem_bus", {mem_addr, mem_data, mem_wr_size}, '0);
      check("rst_flags", {empty, wr_req_ready, chk_hit}, 3'b110);
      check("rst_count", count, 0);
      reset = 1'b1;
      tick();

      // Single aligned word
      push_store(32'h100, 64'hDDCC_BBAA, 2'd2);
      drain_head(0);
      check("empty_after_t1", empty, 1'b1);

      // Unaligned doubleword: three beats
      push_store(32'h103, 64'h8877_6655_4433_2211, 2'd3);
      drain_head(2);

      // Fill without grant; fifth push refused
      for (int i = 0; i < 5; i++)
         push_store(32'h400 + 32'(16 * i), {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      check("full_count", count, 4);
      check("full_ready", wr_req_ready, 1'b0);
      check("req_pending", mem_req, 1'b1);
      mem_data_valid = 1'b1;
      tick();
      mem_data_valid = 1'b0;
      check("stray_ack", count, 4);
      drain_head(1);
      check("ready_after_pop", wr_req_ready, 1'b1);
      push_store(32'h7777, 64'h0123_4567_89AB_CDEF, 2'd3);
      while (q.size() > 0) drain_head(1);

      // Hazard window on a block-straddling store
      push_store(32'h1FF, 64'hBEEF, 2'd1);
      chk_address = 32'h1F8; #1 check("hit_1f8", chk_hit, 1'b1);
      chk_address = 32'h200; #1 check("hit_200", chk_hit, 1'b1);
      chk_address = 32'h208; #1 check("hit_208", chk_hit, 1'b0);
      drain_head(0);
      chk_address = 32'h200; #1 check("hit_after_ack", chk_hit, 1'b0);

      // Busy bus blocks a granted request; idle passes grant through
      push_store(32'h40, 64'h55, 2'd0);
      grant_in = 1'b1; bus_busy_in = 1'b1;
      repeat (5) tick();
      check("busy_req", mem_req, 1'b1);
      check("busy_en", mem_en, 1'b0);
      check("busy_gout", grant_out, 1'b0);
      bus_busy_in = 1'b0;
      drain_head(0);
      repeat (2) tick();
      for (int g = 0; g < 2; g++) begin
         grant_in = 1'(g);
         #1 check("idle_gout", grant_out, grant_in);
      end

      // Wrap-around address
      push_store(32'hFFFF_FFFE, 64'h1122_3344_5566_7788, 2'd3);
      drain_head(1);

      // Asynchronous reset in the middle of a three-beat store
      push_store(32'h103, 64'h8877_6655_4433_2211, 2'd3);
      grant_in = 1'b1;
      n = 0;
      while (!mem_en && n < 40) begin tick(); n++; end
      grant_in = 1'b0;
      mem_data_valid = 1'b1;
      tick();
      mem_data_valid = 1'b0;
      check("mid_beat2", mem_addr, 32'h104);
      #2 reset = 1'b0;
      #1;
      check("arst_busy", {bus_busy_out, mem_en, mem_req}, 3'b000);
      check("arst_count", count, 0);
      check("arst_empty", empty, 1'b1);
      q.delete();
      @(negedge clk) reset = 1'b1;
      tick();

      // Randomized batches
      for (int b = 0; b < 12; b++) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            s.a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            s.d  = {$urandom, $urandom};
            s.sz = 2'($urandom_range(0, 3));
            push_store(s.a, s.d, s.sz);
         end
         check("rnd_count", count, q.size());
         for (int k = 0; k < 4; k++) begin
            chk_address = q[$urandom_range(0, q.size() - 1)].a + 32'($urandom_range(0, 16)) - 32'd8;
            #1 check("rnd_hit", chk_hit, model_hit(chk_address));
         end
         while (q.size() > 0) drain_head(2);
         check("rnd_empty", empty, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
